dct_rle_encoder: RTL and testbench
==================================

Name: dct_rle_encoder

Overview:
- Downstream stage of the DCT array. Consumes the serialised 18-bit signed DCT coefficients, 8 per block in z1..z8 order.
- Quantises each coefficient by a power-of-two shift and run-length encodes the zeros into (run, level) tokens, with an end-of-block (EOB) token closing every block.
- Its output feeds the compressed-stream packer.

Parameters:
- IN_W, 18: coefficient width, signed.
- BLOCK_LEN, 8: coefficients per block.
- QSHIFT, 4: quantiser shift (divide by 2^QSHIFT).
- LVL_W, 12: quantised level width, signed.
- RUN_W, 3: run width, equal to clog2(BLOCK_LEN).
- FIFO_DEPTH, 4: output token FIFO depth, at least 2.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: coefficient valid.
- in_ready, output, 1: stage can accept a coefficient.
- in_coef, input, IN_W: signed DCT coefficient.
- out_valid, output, 1: token valid.
- out_ready, input, 1: downstream accepts the token.
- out_run, output, RUN_W: number of zero coefficients preceding the level.
- out_level, output, LVL_W: signed quantised level; 0 for EOB.
- out_eob, output, 1: token is end-of-block.

Behaviour:
- Reset: all state clears immediately and asynchronously.
  - FIFO emptied; coefficient index counter and run counter set to 0.
  - Outputs: out_valid=0, out_run=0, out_level=0, out_eob=0, in_ready=0 while reset is high, then 1 on the first cycle after release.
- Handshakes:
  - Accept on the cycle with in_valid && in_ready.
  - Pop on the cycle with out_valid && out_ready.
  - in_ready = (FIFO free entries >= 2), decoded combinationally from the registered count.
- Quantisation, truncation toward zero:
  - If in_coef < 0, add 2^QSHIFT-1 before the arithmetic right shift by QSHIFT.
  - Saturate the result to [-2^(LVL_W-1), 2^(LVL_W-1)-1], i.e. [-2048, 2047] by default.
- Coefficient index idx runs 0..BLOCK_LEN-1 and wraps to 0 after each block.
- Per accepted coefficient, with q its quantised value:
  - q==0 and idx<BLOCK_LEN-1: run++, no token.
  - q!=0 and idx<BLOCK_LEN-1: push (run, q, eob=0), run<=0.
  - idx==BLOCK_LEN-1 and q!=0: push (run, q, 0) then (0, 0, eob=1) in the same cycle (two writes); run<=0.
  - idx==BLOCK_LEN-1 and q==0: push EOB only (trailing zeros dropped); run<=0.
- Run range: run never exceeds BLOCK_LEN-1 (7), so it fits RUN_W with no escape code.
- FIFO: first-word fall-through.
  - A token pushed in cycle N is visible on out_* in cycle N+1 when the FIFO was empty. Latency is 1 cycle.
  - Simultaneous push (1 or 2 entries) and pop in one cycle updates count by pushes-1.
  - No overflow is possible because in_ready guarantees 2 free entries.
  - Popping an empty FIFO is impossible because out_valid=0.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Reset mid-block: the partial block and all queued tokens are discarded; the next accepted coefficient is idx 0.

Optional Feature:
- Macro RLE_SAT_FLAG_EN.
- Defined: adds output port sat_flag (1 bit). It is sticky and set in the cycle after any accepted coefficient saturates in the quantiser. It is cleared only by reset, where its reset value is 0.
- Undefined: the port is absent and there is no flag logic. Saturation is still applied identically.

Test Plan:
1. Block [160,0,0,-48,0,0,0,0], out_ready=1 -> tokens (0,10,0), (2,-3,0), (0,0,1); no other tokens.
2. Block of eight zeros -> single token (0,0,1); run counter back to 0 for the next block.
3. Block [0,0,0,0,0,0,0,32] with out_ready=0 from the start:
   - Final accept pushes 2 tokens: FIFO count 2, in_ready stays 1 (2 free of 4).
   - A following 7-zero block plus nonzero last coefficient pushes 2 more; in_ready drops to 0 at count 4.
   - Release out_ready -> (7,2,0), (0,0,1), (7,q,0), (0,0,1) in order.
4. Truncation: coefficients -15, -16, -17, 15, 16 at idx 0..4 -> q values 0, -1, -1, 0, 1; tokens (1,-1), (0,-1), (1,1).
5. Saturation: in_coef 131071 -> level 2047; -131072 -> level -2048; with RLE_SAT_FLAG_EN, sat_flag rises the cycle after the first and stays 1.
6. Reset mid-block:
   - Accept 3 coefficients, assert reset for 1 cycle -> out_valid=0, FIFO empty.
   - Next block [16,0,...,0] -> (0,1,0), (0,0,1); no stale tokens.

Source files
------------

// File: rtl/dct_rle_encoder.sv
// Quantises serialised DCT coefficients and run-length codes them into (run, level, eob) tokens.
// Optional sticky saturation flag output when RLE_SAT_FLAG_EN is defined.
module dct_rle_encoder #(
    parameter int IN_W       = 18,
    parameter int BLOCK_LEN  = 8,
    parameter int QSHIFT     = 4,
    parameter int LVL_W      = 12,
    parameter int RUN_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_coef,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RUN_W-1:0] out_run,
    output logic [LVL_W-1:0] out_level,
    output logic             out_eob
`ifdef RLE_SAT_FLAG_EN
    ,
    output logic             sat_flag
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TOK_W = 1 + RUN_W + LVL_W;

    localparam logic signed [IN_W:0] LVL_MAX = (IN_W+1)'((1 << (LVL_W-1)) - 1);
    localparam logic signed [IN_W:0] LVL_MIN = (IN_W+1)'(-(1 << (LVL_W-1)));
    localparam logic signed [IN_W:0] BIAS    = (IN_W+1)'((1 << QSHIFT) - 1);
    localparam logic [TOK_W-1:0]     TOK_EOB = {1'b1, {(RUN_W+LVL_W){1'b0}}};

    // Biasing negatives before the arithmetic shift makes it truncate toward zero.
    function automatic logic signed [IN_W:0] quant_shift(input logic signed [IN_W-1:0] c);
        logic signed [IN_W:0] t;
        t = {c[IN_W-1], c};
        if (c[IN_W-1])
            t = t + BIAS;
        return t >>> QSHIFT;
    endfunction

    function automatic logic signed [LVL_W-1:0] saturate(input logic signed [IN_W:0] v);
        if (v > LVL_MAX)
            return LVL_MAX[LVL_W-1:0];
        else if (v < LVL_MIN)
            return LVL_MIN[LVL_W-1:0];
        return v[LVL_W-1:0];
    endfunction

    function automatic logic overflowed(input logic signed [IN_W:0] v);
        return (v > LVL_MAX) || (v < LVL_MIN);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= FIFO_DEPTH)
            s = s - FIFO_DEPTH;
        return PTR_W'(s);
    endfunction

    logic signed [IN_W-1:0]  coef_s;
    logic signed [IN_W:0]    qfull;
    logic signed [LVL_W-1:0] q;
    logic                    acc, last, nz, pop;
    logic [1:0]              n_push;
    logic [TOK_W-1:0]        tok_a, head;

    logic [RUN_W-1:0]        idx, run;
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        count;
    logic [TOK_W-1:0]        mem [FIFO_DEPTH];

    assign coef_s = in_coef;
    assign qfull  = quant_shift(coef_s);
    assign q      = saturate(qfull);
    assign nz     = (q != '0);
    assign last   = (idx == RUN_W'(BLOCK_LEN - 1));
    assign acc    = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign tok_a  = nz ? {1'b0, run, q} : TOK_EOB;

    always_comb begin
        n_push = 2'd0;
        if (acc) begin
            if (nz && last)
                n_push = 2'd2;
            else if (nz || last)
                n_push = 2'd1;
        end
    end

    // Stage boundary: quantised token written into the output FIFO.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0)
            mem[wr_ptr] <= tok_a;
        if (n_push == 2'd2)
            mem[ptr_inc(wr_ptr, 2'd1)] <= TOK_EOB;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            idx    <= '0;
            run    <= '0;
        end else begin
            wr_ptr <= ptr_inc(wr_ptr, n_push);
            rd_ptr <= ptr_inc(rd_ptr, {1'b0, pop});
            count  <= count + CNT_W'(n_push) - CNT_W'(pop);
            if (acc) begin
                idx <= last ? '0 : idx + 1'b1;
                run <= (nz || last) ? '0 : run + 1'b1;
            end
        end
    end

`ifdef RLE_SAT_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_flag <= 1'b0;
        else if (acc && overflowed(qfull))
            sat_flag <= 1'b1;
    end
`endif

    // Two free slots are required because the last coefficient can push two tokens.
    assign in_ready  = !reset && (count <= CNT_W'(FIFO_DEPTH - 2));
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_eob   = out_valid && head[TOK_W-1];
    assign out_run   = out_valid ? head[TOK_W-2 -: RUN_W] : '0;
    assign out_level = out_valid ? head[LVL_W-1:0] : '0;

endmodule

// File: tb/tb_dct_rle_encoder.sv
// Directed and randomized bench for dct_rle_encoder with a block-level token reference model.
module tb_dct_rle_encoder;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [17:0] in_coef = '0;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_run;
    logic [11:0]        out_level;
    logic               out_eob;
`ifdef RLE_SAT_FLAG_EN
    logic               sat_flag;
`endif

    logic ready_fix = 1'b1;
    logic rand_bp_en = 1'b0;
    logic bp_rand = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic        hold_prev = 1'b0;
    logic [15:0] tok_prev = '0;
    logic [15:0] cur;

    assign out_ready = rand_bp_en ? bp_rand : ready_fix;

    dct_rle_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_run   (out_run),
        .out_level (out_level),
        .out_eob   (out_eob)
`ifdef RLE_SAT_FLAG_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) bp_rand <= ($urandom_range(0, 3) != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tok(input int eob, input int run, input int lvl);
        return {1'(eob), 3'(run), 12'(lvl)};
    endfunction

    // Reference: divide truncates toward zero, clamp, emit nonzeros with their zero runs, then EOB.
    function automatic void model_block(input int c[8]);
        int run;
        int q;
        run = 0;
        for (int i = 0; i < 8; i++) begin
            q = c[i] / 16;
            if (q > 2047) q = 2047;
            if (q < -2048) q = -2048;
            if (q != 0) begin
                exp_q.push_back(tok(0, run, q));
                run = 0;
            end else begin
                run++;
            end
        end
        exp_q.push_back(tok(1, 0, 0));
    endfunction

    // Token collector and hold-stability monitor.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cur = {out_eob, out_run, out_level};
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_tok", 32'(cur), 32'(tok_prev));
                end
                if (out_valid && out_ready)
                    got_q.push_back(cur);
                hold_prev = out_valid && !out_ready;
                tok_prev  = cur;
            end
        end
    end

    task automatic send_coef(input int c);
        int w;
        in_valid = 1'b1;
        in_coef  = 18'(c);
        w = 0;
        while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int c[8]);
        model_block(c);
        for (int i = 0; i < 8; i++)
            send_coef(c[i]);
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (got_q.size() < exp_q.size() && w < 600) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_ntok"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_tok%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int blk[8];
        int r;

        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_run", 32'(out_run), 32'd0);
        check("rst_out_level", 32'(out_level), 32'd0);
        check("rst_out_eob", 32'(out_eob), 32'd0);
`ifdef RLE_SAT_FLAG_EN
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);

        // Basic block with full-rate output.
        blk = '{160, 0, 0, -48, 0, 0, 0, 0};
        send_block(blk);
        repeat (4) @(negedge clk);
        check("t1_n", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("t1_a", 32'(got_q[0]), 32'(tok(0, 0, 10)));
            check("t1_b", 32'(got_q[1]), 32'(tok(0, 2, -3)));
            check("t1_c", 32'(got_q[2]), 32'(tok(1, 0, 0)));
        end
        drain("t1");

        blk = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_block(blk);
        drain("t2");

        // Backpressure: two blocks fill the FIFO to its depth.
        ready_fix = 1'b0;
        blk = '{0, 0, 0, 0, 0, 0, 0, 32};
        send_block(blk);
        #1;
        check("t3_valid_a", 32'(out_valid), 32'd1);
        check("t3_ready_a", 32'(in_ready), 32'd1);
        check("t3_head_run", 32'(out_run), 32'd7);
        check("t3_head_lvl", 32'(out_level), 32'd2);
        check("t3_head_eob", 32'(out_eob), 32'd0);
        blk = '{0, 0, 0, 0, 0, 0, 0, 48};
        send_block(blk);
        #1;
        check("t3_ready_full", 32'(in_ready), 32'd0);
        check("t3_valid_full", 32'(out_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("t3_held_run", 32'(out_run), 32'd7);
        ready_fix = 1'b1;
        drain("t3");

        blk = '{-15, -16, -17, 15, 16, 0, 0, 0};
        send_block(blk);
        drain("t4");

        // Saturation at both ends of the level range.
        blk = '{131071, -131072, 0, 0, 0, 0, 0, 0};
        model_block(blk);
`ifdef RLE_SAT_FLAG_EN
        check("t5_sat_pre", 32'(sat_flag), 32'd0);
`endif
        send_coef(blk[0]);
`ifdef RLE_SAT_FLAG_EN
        check("t5_sat_set", 32'(sat_flag), 32'd1);
`endif
        for (int i = 1; i < 8; i++)
            send_coef(blk[i]);
`ifdef RLE_SAT_FLAG_EN
        check("t5_sat_sticky", 32'(sat_flag), 32'd1);
`endif
        drain("t5");

        // Reset in the middle of a block with tokens still queued.
        ready_fix = 1'b0;
        send_coef(16);
        send_coef(0);
        send_coef(16);
        #1;
        check("t6_queued", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        check("t6_rst_level", 32'(out_level), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rel_valid", 32'(out_valid), 32'd0);
        check("t6_rel_ready", 32'(in_ready), 32'd1);
        got_q.delete();
        ready_fix = 1'b1;
        blk = '{16, 0, 0, 0, 0, 0, 0, 0};
        send_block(blk);
        drain("t6");

        // Random blocks under random backpressure.
        rand_bp_en = 1'b1;
        for (int b = 0; b < 30; b++) begin
            for (int i = 0; i < 8; i++) begin
                r = int'($urandom_range(0, 9));
                if (r <= 3)
                    blk[i] = 0;
                else if (r <= 6)
                    blk[i] = int'($urandom_range(0, 200)) - 100;
                else if (r <= 8)
                    blk[i] = int'($urandom_range(0, 80000)) - 40000;
                else
                    blk[i] = ($urandom_range(0, 1) != 0) ? 131071 : -131072;
            end
            send_block(blk);
        end
        drain("rand");
        rand_bp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
